lbr_trace_export: RTL and testbench

Downstream consumer of the LBR unit's branch-record writes. Every taken JAL/JALR that the LBR unit commits (its PC/target write event) is captured here as one record, buffered in a small FIFO, and serialized as two DATA_WIDTH words over a valid/ready stream to the off-core trace monitor. Records that arrive while the buffer is full are dropped and counted. A per-record sequence number lets the monitor detect the gaps.

---
 rtl/lbr_pkg.sv | 31 +++
 rtl/lbr_trace_export_if.sv | 12 +
 rtl/lbr_rec_fifo.sv | 49 ++++
 rtl/lbr_trace_export.sv | 159 +++++++++++++++
 tb/tb_lbr_trace_export.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbr_pkg.sv
// Shared types and word-layout constants for the LBR trace exporter.
package lbr_pkg;

  // Reference widths; the layout constants below are expressed for this
  // word width and rebased by the top level for other DATA_WIDTH values.
  localparam int LBR_DATA_WIDTH = 32;
  localparam int LBR_ADDR_BITS  = 20;

  localparam int SEQ_WIDTH = 8;
  localparam int KIND_BIT  = LBR_DATA_WIDTH - 1;
  localparam int SEQ_MSB   = LBR_DATA_WIDTH - 1;
  localparam int SEQ_LSB   = LBR_DATA_WIDTH - SEQ_WIDTH;

  localparam logic KIND_JAL  = 1'b0;
  localparam logic KIND_JALR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FROM = 2'd1,
    TO   = 2'd2
  } ser_state_e;

  // One buffered branch record.
  typedef struct packed {
    logic                     kind;
    logic [SEQ_WIDTH-1:0]     seq;
    logic [LBR_ADDR_BITS-1:0] from;
    logic [LBR_ADDR_BITS-1:0] to;
  } lbr_rec_t;

endpackage

// File: rtl/lbr_trace_export_if.sv
// Valid/ready word stream toward the off-core trace monitor.
interface lbr_trace_export_if #(
  parameter int DATA_WIDTH = lbr_pkg::LBR_DATA_WIDTH
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (output out_valid, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/lbr_rec_fifo.sv
// Synchronous record FIFO with same-cycle push/pop, exposing the head and
// the entry behind it so the serializer can chain records without a bubble.
module lbr_rec_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] second,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  assign head   = mem[rd_ptr];
  assign second = mem[rd_ptr + AW'(1)];
  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);

  // Storage needs no reset; a push while full (with pop) lands in the slot
  // being vacated, which is read before the edge.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

endmodule

// File: rtl/lbr_trace_export.sv
// Captures committed JAL/JALR branch records, buffers them and streams each
// as two words (from-PC, then seq + target) to the trace monitor.
module lbr_trace_export
  import lbr_pkg::*;
#(
  parameter int DATA_WIDTH   = LBR_DATA_WIDTH,
  parameter int ADDRESS_BITS = LBR_ADDR_BITS,
  parameter int FIFO_DEPTH   = 8,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    rec_valid,
  input  logic                    rec_kind,
  input  logic [ADDRESS_BITS-1:0] rec_from,
  input  logic [ADDRESS_BITS-1:0] rec_to,
  input  logic                    enable,
  input  logic                    drop_clear,
  lbr_trace_export_if.master      strm,
  output logic [15:0]             drop_count,
  output logic [LW-1:0]           fifo_level
);

  // Layout constants rebased from the package's reference word width.
  localparam int KIND_B = KIND_BIT - LBR_DATA_WIDTH + DATA_WIDTH;
  localparam int SEQ_M  = SEQ_MSB - LBR_DATA_WIDTH + DATA_WIDTH;
  localparam int SEQ_L  = SEQ_LSB - LBR_DATA_WIDTH + DATA_WIDTH;
  localparam int RW     = $bits(lbr_rec_t);

  logic                 cap, push, pop, drop, more;
  logic                 fifo_full, fifo_empty;
  logic [SEQ_WIDTH-1:0] seq;
  logic [RW-1:0]        head_raw, second_raw;
  lbr_rec_t             new_rec, head_rec, second_rec, next_head;
  ser_state_e           state;

  function automatic logic [DATA_WIDTH-1:0] word0(lbr_rec_t r);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[KIND_B] = r.kind;
    w[ADDRESS_BITS-1:0] = ADDRESS_BITS'(r.from);
    return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] word1(lbr_rec_t r);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[SEQ_M:SEQ_L] = r.seq;
    w[ADDRESS_BITS-1:0] = ADDRESS_BITS'(r.to);
    return w;
  endfunction

  // A full buffer still accepts when the head leaves in the same cycle.
  assign cap  = rec_valid & ~stall & enable;
  assign pop  = (state == TO) & strm.out_ready;
  assign push = cap & (~fifo_full | pop);
  assign drop = cap & ~push;

  // Record being offered this cycle; carries the current sequence number.
  always_comb begin
    new_rec      = '0;
    new_rec.kind = rec_kind;
    new_rec.seq  = seq;
    new_rec.from = rec_from;
    new_rec.to   = rec_to;
  end

  assign head_rec   = lbr_rec_t'(head_raw);
  assign second_rec = lbr_rec_t'(second_raw);

  // After popping the head, the next record is either already buffered or
  // is the one being pushed into an otherwise empty buffer.
  assign more      = (fifo_level > LW'(1)) | push;
  assign next_head = (fifo_level > LW'(1)) ? second_rec : new_rec;

  lbr_rec_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wdata  (new_rec),
    .head   (head_raw),
    .second (second_raw),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Sequence number advances only on accepted records, so drops leave gaps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) seq <= '0;
    else if (push) seq <= seq + SEQ_WIDTH'(1);
  end

  // Saturating drop counter; a clear coinciding with a drop leaves one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop_clear) begin
      drop_count <= drop ? 16'd1 : 16'd0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // Serializer: word0 then word1 per record, outputs registered and held
  // while the monitor stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      strm.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state          <= FROM;
            strm.out_valid <= 1'b1;
            strm.out_data  <= word0(head_rec);
            strm.out_last  <= 1'b0;
          end
        end
        FROM: begin
          if (strm.out_ready) begin
            state         <= TO;
            strm.out_data <= word1(head_rec);
            strm.out_last <= 1'b1;
          end
        end
        TO: begin
          if (strm.out_ready) begin
            if (more) begin
              state         <= FROM;
              strm.out_data <= word0(next_head);
              strm.out_last <= 1'b0;
            end else begin
              state          <= IDLE;
              strm.out_valid <= 1'b0;
              strm.out_data  <= '0;
              strm.out_last  <= 1'b0;
            end
          end
        end
        default: begin
          state          <= IDLE;
          strm.out_valid <= 1'b0;
          strm.out_data  <= '0;
          strm.out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbr_trace_export.sv
// Randomized + directed bench for lbr_trace_export with a transaction-level
// reference model feeding an expected-word scoreboard.
module tb_lbr_trace_export;
  import lbr_pkg::*;

  localparam int DW = 32;
  localparam int AB = 20;
  localparam int D  = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          rec_valid = 1'b0;
  logic          rec_kind = 1'b0;
  logic          enable = 1'b1;
  logic          drop_clear = 1'b0;
  logic [AB-1:0] rec_from = '0;
  logic [AB-1:0] rec_to = '0;
  logic [15:0]   drop_count;
  logic [3:0]    fifo_level;

  lbr_trace_export_if #(.DATA_WIDTH(DW)) strm ();

  lbr_trace_export #(
    .DATA_WIDTH   (DW),
    .ADDRESS_BITS (AB),
    .FIFO_DEPTH   (D)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .rec_valid  (rec_valid),
    .rec_kind   (rec_kind),
    .rec_from   (rec_from),
    .rec_to     (rec_to),
    .enable     (enable),
    .drop_clear (drop_clear),
    .strm       (strm),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Records accepted -> expected words queued as {last, data}.
  logic [32:0] exp_q[$];
  int m_lvl = 0;   // records buffered
  int m_ph = 0;    // 0 nothing shown, 1 showing word0, 2 showing word1
  int m_seq = 0;
  int m_drop = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_lvl = 0; m_ph = 0; m_seq = 0; m_drop = 0;
      exp_q.delete();
    end else begin
      bit cap, pop, push, drop;
      int old_lvl;
      old_lvl = m_lvl;
      cap  = rec_valid && !stall && enable;
      pop  = (m_ph == 2) && strm.out_ready;
      push = cap && (m_lvl < D || pop);
      drop = cap && !push;
      if (drop_clear) m_drop = drop ? 1 : 0;
      else if (drop && m_drop < 65535) m_drop++;
      if (push) begin
        exp_q.push_back({1'b0, (32'(rec_kind) << 31) | 32'(rec_from)});
        exp_q.push_back({1'b1, (32'(m_seq) << 24) | 32'(rec_to)});
        m_seq = (m_seq + 1) % 256;
      end
      m_lvl = m_lvl + int'(push) - int'(pop);
      case (m_ph)
        0: m_ph = (old_lvl != 0) ? 1 : 0;
        1: m_ph = strm.out_ready ? 2 : 1;
        default: if (strm.out_ready) m_ph = (m_lvl != 0) ? 1 : 0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  bit          hold_prev = 0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clock) begin
    if (reset) begin
      chk("level", 64'(fifo_level), 64'(m_lvl));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      chk("out_valid", 64'(strm.out_valid), 64'(m_ph != 0));
      if (strm.out_valid) begin
        if (hold_prev) begin
          chk("hold_data", 64'(strm.out_data), 64'(prev_data));
          chk("hold_last", 64'(strm.out_last), 64'(prev_last));
        end
        if (strm.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(strm.out_data), 64'hDEAD_0000_0000);
          end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            chk("word", 64'(strm.out_data), 64'(e[31:0]));
            chk("last", 64'(strm.out_last), 64'(e[32]));
          end
        end
      end else begin
        chk("idle_data", 64'(strm.out_data), 64'd0);
        chk("idle_last", 64'(strm.out_last), 64'd0);
      end
      hold_prev = strm.out_valid && !strm.out_ready;
      prev_data = strm.out_data;
      prev_last = strm.out_last;
    end else begin
      hold_prev = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input bit v, input bit k, input logic [AB-1:0] f, input logic [AB-1:0] t);
    rec_valid = v; rec_kind = k; rec_from = f; rec_to = t;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (fifo_level != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    chk(name, 64'(fifo_level), 64'd0);
  endtask

  task automatic wait_last(input string name, input int budget);
    int n;
    n = 0;
    while (!strm.out_last && n < budget) begin
      cyc(1);
      n++;
    end
    chk(name, 64'(strm.out_last), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tmp;
    int d0;
    strm.out_ready = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_valid", 64'(strm.out_valid), 64'd0);
    chk("rst_data", 64'(strm.out_data), 64'd0);
    chk("rst_last", 64'(strm.out_last), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b1;
    cyc(1);

    // Single JAL: latency and word layout
    strm.out_ready = 1'b1;
    drive(1, KIND_JAL, 20'h00100, 20'h00200);
    cyc(1);
    chk("jal_level_k", 64'(fifo_level), 64'd1);
    chk("jal_valid_k", 64'(strm.out_valid), 64'd0);
    drive(0, 0, '0, '0);
    cyc(1);
    chk("jal_w0", 64'(strm.out_data), 64'h0000_0100);
    chk("jal_w0_last", 64'(strm.out_last), 64'd0);
    cyc(1);
    chk("jal_w1", 64'(strm.out_data), 64'h0000_0200);
    chk("jal_w1_last", 64'(strm.out_last), 64'd1);
    cyc(1);
    chk("jal_done_valid", 64'(strm.out_valid), 64'd0);
    chk("jal_done_level", 64'(fifo_level), 64'd0);

    // Backpressure while in FROM
    strm.out_ready = 1'b0;
    drive(1, KIND_JALR, 20'h0ABCD, 20'h0DCBA);
    cyc(1);
    drive(0, 0, '0, '0);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(strm.out_valid), 64'd1);
      chk("bp_data", 64'(strm.out_data), 64'h8000_ABCD);
      cyc(1);
    end
    strm.out_ready = 1'b1;
    wait_empty("bp_drain", 20);

    // Overflow: 10 JALR captures into a depth-8 buffer
    pulse_reset();
    strm.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1, KIND_JALR, AB'($urandom), AB'($urandom));
      cyc(1);
    end
    drive(0, 0, '0, '0);
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_drop", 64'(drop_count), 64'd2);
    strm.out_ready = 1'b1;
    wait_empty("ovf_drain", 40);
    drive(1, KIND_JAL, 20'h11111, 20'h22222);
    cyc(1);
    drive(0, 0, '0, '0);
    wait_last("ovf_next_wait", 10);
    tmp = strm.out_data;
    chk("ovf_next_seq", 64'(tmp[31:24]), 64'd8);
    wait_empty("ovf_next_drain", 10);

    // Full buffer with pop and capture in the same cycle
    strm.out_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      drive(1, $urandom_range(0, 1), AB'($urandom), AB'($urandom));
      cyc(1);
    end
    strm.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1, $urandom_range(0, 1), AB'($urandom), AB'($urandom));
      cyc(1);
      chk("fullpop_level", 64'(fifo_level), 64'd8);
    end
    drive(0, 0, '0, '0);
    wait_empty("fullpop_drain", 40);

    // Gating: stall or enable=0 neither pushes nor drops
    d0 = m_drop;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, AB'($urandom), AB'($urandom));
      cyc(1);
    end
    chk("stall_level", 64'(fifo_level), 64'd0);
    chk("stall_drop", 64'(drop_count), 64'(d0));
    stall = 1'b0;
    enable = 1'b0;
    cyc(3);
    chk("enable_level", 64'(fifo_level), 64'd0);
    chk("enable_drop", 64'(drop_count), 64'(d0));
    enable = 1'b1;
    drive(0, 0, '0, '0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 3) != 0, $urandom_range(0, 1), AB'($urandom), AB'($urandom));
      stall          = ($urandom % 5) == 0;
      enable         = ($urandom % 8) != 0;
      drop_clear     = ($urandom % 64) == 0;
      strm.out_ready = ($urandom % 3) != 0;
      cyc(1);
    end
    drive(0, 0, '0, '0);
    stall = 1'b0; enable = 1'b1; drop_clear = 1'b0;
    strm.out_ready = 1'b1;
    wait_empty("rand_drain", 40);

    // Reset while word1 is on the bus
    drive(1, 0, 20'h00AAA, 20'h00BBB);
    cyc(1);
    drive(0, 0, '0, '0);
    wait_last("midrst_wait", 10);
    reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(strm.out_valid), 64'd0);
    chk("midrst_last", 64'(strm.out_last), 64'd0);
    chk("midrst_level", 64'(fifo_level), 64'd0);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    drive(1, 0, 20'h00777, 20'h12345);
    cyc(1);
    drive(0, 0, '0, '0);
    wait_last("midrst_next_wait", 10);
    chk("midrst_seq0", 64'(strm.out_data), 64'h0001_2345);
    wait_empty("midrst_drain", 10);

    // drop_count saturation and clear
    pulse_reset();
    strm.out_ready = 1'b0;
    drive(1, 1, 20'h0F0F0, 20'h00F0F);
    cyc(D + 65535 + 10);
    chk("sat_drop", 64'(drop_count), 64'hFFFF);
    rec_valid = 1'b0;
    drop_clear = 1'b1;
    cyc(1);
    chk("clear_drop", 64'(drop_count), 64'd0);
    rec_valid = 1'b1;
    cyc(1);
    chk("clear_with_drop", 64'(drop_count), 64'd1);
    drop_clear = 1'b0;
    rec_valid = 1'b0;
    strm.out_ready = 1'b1;
    wait_empty("sat_drain", 40);
    cyc(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
